uartrx_parity: RTL and testbench

- Serial receiver for the odd-parity UART link. It sits directly downstream of the team's uarttx transmitter, which drives idle-high frames.
- Frame format: start(0), d0..d7 LSB first, odd parity bit, stop(1).
- Recovers each byte by mid-bit sampling in the system clock domain, using a clock-enable counter rather than a derived clock.
- Presents the byte with a one-cycle done pulse plus parity and framing error flags to the consuming logic.

---
 rtl/uartrx_parity.sv | 145 ++++++++++++++
 tb/tb_uartrx_parity.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uartrx_parity.sv
// Odd-parity UART receiver: 8 data bits LSB first, one parity bit, one stop bit.
// It samples each bit at mid-period using a clock-enable counter in the clk domain.
module uartrx_parity #(
    parameter int unsigned clk_freq  = 1000000,
    parameter int unsigned baud_rate = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       donerx,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);
    localparam int unsigned clkcount = clk_freq / baud_rate;
    localparam int unsigned CNT_W    = $clog2(clkcount);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(clkcount / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(clkcount - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BRK
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bitidx_q, bitidx_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             done_q, done_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;
    logic             busy_q, busy_d;
    logic             rx_meta_q, rx_s_q;

    // Two-flop synchronizer; it resets to the idle-high line level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bitidx_q  <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            rx_data_q <= '0;
            done_q    <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bitidx_q  <= bitidx_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            rx_data_q <= rx_data_d;
            done_q    <= done_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bitidx_d  = bitidx_q;
        shift_d   = shift_q;
        par_d     = par_q;
        rx_data_d = rx_data_q;
        done_d    = 1'b0;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                // A line that is high again at half a bit period was a glitch, not a start bit.
                if (cnt_q == CNT_HALF) begin
                    cnt_d    = '0;
                    bitidx_d = '0;
                    state_d  = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d            = '0;
                    shift_d[bitidx_q] = rx_s_q;
                    bitidx_d         = bitidx_q + 3'd1;
                    if (bitidx_q == 3'd7) state_d = S_PARITY;
                end
            end
            S_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    par_d   = rx_s_q;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    rx_data_d = shift_q;
                    perr_d    = ~(^{shift_q, par_q});
                    ferr_d    = ~rx_s_q;
                    done_d    = 1'b1;
                    state_d   = rx_s_q ? S_IDLE : S_BRK;
                end
            end
            S_BRK: begin
                cnt_d = '0;
                if (rx_s_q) state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    assign rx_data    = rx_data_q;
    assign donerx     = done_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uartrx_parity.sv
// Self-checking bench for uartrx_parity: directed frame table, corner sequences,
// and random frames checked against a frame-level reference model.
module tb_uartrx_parity;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic [7:0] rx_data;
    logic       donerx, parity_err, frame_err, busy;

    uartrx_parity #(.clk_freq(1000000), .baud_rate(9600)) dut (
        .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .donerx(donerx),
        .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_err = 0;
    logic prev_done = 1'b0;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         c;
    } obs_t;
    obs_t obs_q[$];

    // Capture every donerx pulse together with the outputs that it qualifies.
    always @(negedge clk) begin
        if (donerx) obs_q.push_back('{rx_data, parity_err, frame_err, cyc});
        if (donerx && prev_done) pulse_err++;
        prev_done = donerx;
    end

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        int         period;
        int         hold;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one frame; the caller must be on a negedge. After a low stop bit the line stays low for hold more clocks.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input int period, input int hold);
        logic [10:0] bits;
        bits = {s, p, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rx = bits[i];
            repeat (period) @(negedge clk);
        end
        if (!s) repeat (hold) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic expect_frame(input string name, input logic [7:0] d, input logic pe,
                                input logic fe, output int done_c);
        int t;
        obs_t o;
        t = 0;
        done_c = -1;
        while (obs_q.size() == 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (obs_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no donerx within bound, got 0 pulses expected 1", name);
        end else begin
            o = obs_q.pop_front();
            done_c = o.c;
            check({name, "_data"}, int'(o.d), int'(d));
            check({name, "_perr"}, int'(o.pe), int'(pe));
            check({name, "_ferr"}, int'(o.fe), int'(fe));
        end
    endtask

    // The reference model works at frame level: it counts 1s across data and parity and reads the stop level.
    function automatic logic model_perr(input logic [7:0] d, input logic p);
        int ones;
        ones = $countones(d) + int'(p);
        return (ones % 2) == 0;
    endfunction

    initial begin
        int start_c, done_c;
        logic [7:0] d;
        logic p, s;
        int per, hold;

        vecs[0] = '{8'h3C, 1'b0, 1'b1, 104, 0, 8'h3C, 1'b1, 1'b0};
        vecs[1] = '{8'h01, 1'b0, 1'b1, 104, 0, 8'h01, 1'b0, 1'b0};
        vecs[2] = '{8'h80, 1'b0, 1'b1, 100, 0, 8'h80, 1'b0, 1'b0};
        vecs[3] = '{8'hC3, 1'b1, 1'b1, 108, 0, 8'hC3, 1'b0, 1'b0};
        vecs[4] = '{8'h0F, 1'b1, 1'b0, 104, 40, 8'h0F, 1'b0, 1'b1};

        // Reset state, then a long stretch of idle line.
        repeat (5) @(negedge clk);
        check("rst_data", int'(rx_data), 0);
        check("rst_done", int'(donerx), 0);
        check("rst_perr", int'(parity_err), 0);
        check("rst_ferr", int'(frame_err), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b1;
        repeat (5000) @(negedge clk);
        check("idle_pulses", obs_q.size(), 0);
        check("idle_busy", int'(busy), 0);
        check("idle_data", int'(rx_data), 0);

        // Clean 0xA5 and its latency from the start edge.
        start_c = cyc;
        send_frame(8'hA5, 1'b1, 1'b1, 104, 0);
        expect_frame("a5", 8'hA5, 1'b0, 1'b0, done_c);
        check("a5_latency_ok", int'((done_c - start_c) >= 1092 && (done_c - start_c) <= 1097), 1);
        repeat (20) @(negedge clk);

        // Directed table.
        foreach (vecs[i]) begin
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stop, vecs[i].period, vecs[i].hold);
            expect_frame($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_perr,
                         vecs[i].exp_ferr, done_c);
            repeat (20) @(negedge clk);
        end

        // A bad stop bit followed by a long break keeps the receiver busy until the line returns high.
        fork
            send_frame(8'hFF, 1'b1, 1'b0, 104, 300);
            begin
                repeat (11 * 104 + 200) @(negedge clk);
                check("brk_busy", int'(busy), 1);
                check("brk_pulses", obs_q.size(), 1);
            end
        join
        expect_frame("ff_brk", 8'hFF, 1'b0, 1'b1, done_c);
        repeat (10) @(negedge clk);
        check("brk_exit_busy", int'(busy), 0);
        send_frame(8'h55, 1'b1, 1'b1, 104, 0);
        expect_frame("55", 8'h55, 1'b0, 1'b0, done_c);
        repeat (20) @(negedge clk);

        // A short low pulse is a false start and leaves the outputs untouched.
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_pulses", obs_q.size(), 0);
        check("glitch_data", int'(rx_data), 8'h55);
        check("glitch_busy", int'(busy), 0);

        // Back-to-back frames at the transmitter's 106-clock bit period.
        send_frame(8'h12, 1'b1, 1'b1, 106, 0);
        send_frame(8'h34, 1'b0, 1'b1, 106, 0);
        expect_frame("b2b0", 8'h12, 1'b0, 1'b0, done_c);
        expect_frame("b2b1", 8'h34, 1'b0, 1'b0, done_c);
        repeat (20) @(negedge clk);

        // Reset during data bit 4 drops the partial frame.
        rx = 1'b0;
        repeat (104) @(negedge clk);
        d = 8'h7E;
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            repeat (104) @(negedge clk);
        end
        rx = d[4];
        repeat (50) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_data", int'(rx_data), 0);
        check("midrst_perr", int'(parity_err), 0);
        check("midrst_ferr", int'(frame_err), 0);
        check("midrst_busy", int'(busy), 0);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (300) @(negedge clk);
        check("midrst_pulses", obs_q.size(), 0);
        send_frame(8'h7E, 1'b1, 1'b1, 104, 0);
        expect_frame("7e", 8'h7E, 1'b0, 1'b0, done_c);
        repeat (300) @(negedge clk);
        check("7e_single", obs_q.size(), 0);

        // Random frames within the bit-period tolerance window.
        for (int k = 0; k < 20; k++) begin
            d    = 8'($urandom_range(0, 255));
            p    = ($urandom_range(0, 3) != 0) ? ~(^d) : (^d);
            s    = ($urandom_range(0, 4) != 0);
            per  = int'($urandom_range(100, 108));
            hold = s ? 0 : int'($urandom_range(10, 200));
            send_frame(d, p, s, per, hold);
            expect_frame($sformatf("rnd%0d", k), d, model_perr(d, p), ~s, done_c);
            repeat (s ? int'($urandom_range(0, 30)) : 10) @(negedge clk);
        end
        repeat (300) @(negedge clk);
        check("rnd_no_extra", obs_q.size(), 0);
        check("pulse_width", pulse_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
